keccak_absorb_ctrl: RTL and testbench
=====================================

KECCAK_ABSORB_CTRL -- requirements
Module: keccak_absorb_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: stream and register-load word width in bits; SHALL divide 1600.
REQ-002 Parameter RATE_WORDS, default 68: words per rate block (1088/16, SHA3-256); legal range 2..(1600/DATA_WIDTH).
REQ-003 ACLK  in  1  sole clock; all state changes on rising edge.
REQ-004 ARESETn  in  1  asynchronous, active-low reset.
REQ-005 s_tdata  in  DATA_WIDTH  message word; s_tvalid  in  1  beat valid; s_tlast  in  1  final message beat.
REQ-006 s_tready  out  1  beat accepted when s_tvalid and s_tready are both high at a rising edge.
REQ-007 reg_data  out  DATA_WIDTH  word for the state-register load port; reg_dest  out  8  word index (255 = clear-all); reg_we  out  1  load strobe.
REQ-008 perm_start  out  1  one-cycle permutation request; perm_done  in  1  one-cycle permutation completion.
REQ-009 busy  out  1  high in every state except IDLE; digest_valid  out  1  one-cycle pulse, hash complete; block_cnt  out  16  blocks permuted in current message.

Function
REQ-010 States SHALL be IDLE, CLEAR, LOAD, PAD, PERM, WAIT and DONE.
REQ-011 IDLE: s_tready=0; on s_tvalid=1 go to CLEAR; the beat is not consumed.
REQ-012 CLEAR: exactly one cycle with reg_we=1, reg_dest=255, reg_data=0; block_cnt<=0, idx<=0; then LOAD.
REQ-013 LOAD: s_tready=1; each accepted beat drives reg_we=1, reg_dest=idx, reg_data=s_tdata on the next cycle (registered, latency 1); idx increments per beat.
REQ-014 LOAD, accepted beat at idx=RATE_WORDS-1 with s_tlast=0: go to PERM; s_tready SHALL drop in the same cycle the transition is registered.
REQ-015 LOAD, accepted beat with s_tlast=1: go to PAD with final flag set; if idx=RATE_WORDS-1, the current block goes to PERM first and padding fills a fresh block starting at idx 0.
REQ-016 PAD: one word per cycle, s_tready=0, from index k (first unused) to RATE_WORDS-1; word k = 0x0006, words k+1..RATE_WORDS-2 = 0, word RATE_WORDS-1 = 0x8000; if k=RATE_WORDS-1 that word = 0x8006; then PERM.
REQ-017 PERM: one cycle, perm_start=1, block_cnt increments (saturates at 0xFFFF); then WAIT.
REQ-018 WAIT: hold all outputs idle until perm_done=1; then LOAD with idx=0 if not final, PAD with idx=0 if padding still pending, else DONE.
REQ-019 DONE: digest_valid=1 for one cycle, then IDLE; perm_done outside WAIT SHALL be ignored.
REQ-020 reg_we SHALL never assert in PERM, WAIT, DONE or IDLE; at most one reg_we per cycle.
REQ-021 s_tvalid dropping mid-block in LOAD SHALL stall without state change; idx is held.

Reset
REQ-022 ARESETn=0 SHALL immediately force IDLE, idx=0, block_cnt=0, final flag=0, and s_tready, reg_we, reg_dest, reg_data, perm_start, busy, digest_valid all 0, including mid-block or during WAIT.
REQ-023 After reset release the first action SHALL be the CLEAR cycle of a new message.

Configuration
REQ-024 Macro ABSORB_PAD_EN defined: padding per REQ-015/016.
REQ-025 ABSORB_PAD_EN undefined: PAD state absent; s_tlast beat goes directly to PERM after its write, then DONE after perm_done; unwritten words keep their cleared/previous value.

Verification
REQ-026 Reset, 3 beats 0x1111,0x2222,0x3333 (last on 3rd) -> CLEAR; writes idx0..2; pad 0x0006 at idx3, zeros idx4..66, 0x8000 at idx67; one perm_start; digest_valid after perm_done; block_cnt=1.
REQ-027 67 beats, last on 67th -> single write 0x8006 at idx67, block_cnt=1.
REQ-028 68 beats, last on 68th -> PERM, then pad block 0x0006 at idx0 ... 0x8000 at idx67, second PERM; block_cnt=2.
REQ-029 140 beats with s_tvalid toggled every other cycle and perm_done delayed 24 cycles -> s_tready=0 throughout WAIT, no lost or duplicated beats, idx sequence contiguous.
REQ-030 ARESETn low during WAIT of block 2 -> all outputs 0 asynchronously; next message starts with CLEAR.
REQ-031 ABSORB_PAD_EN undefined, 3 beats -> no pad writes, perm_start one cycle after idx2 write, block_cnt=1.

Source files
------------

// File: rtl/keccak_absorb_ctrl_if.sv
// Bundles the message stream, state-register load port and permutation handshake of the absorb controller.
// master = environment (drives the stream and perm_done), slave = controller.
interface keccak_absorb_ctrl_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tlast;
    logic                  s_tready;

    logic [DATA_WIDTH-1:0] reg_data;
    logic [7:0]            reg_dest;
    logic                  reg_we;

    logic                  perm_start;
    logic                  perm_done;

    logic                  busy;
    logic                  digest_valid;
    logic [15:0]           block_cnt;

    modport master (
        output s_tdata, s_tvalid, s_tlast, perm_done,
        input  s_tready, reg_data, reg_dest, reg_we, perm_start,
               busy, digest_valid, block_cnt
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, perm_done,
        output s_tready, reg_data, reg_dest, reg_we, perm_start,
               busy, digest_valid, block_cnt
    );
endinterface

// File: rtl/keccak_absorb_ctrl.sv
// Keccak absorb sequencer: clears the state, loads rate blocks, pads (macro ABSORB_PAD_EN) and requests permutations.
// Latency: a load-port write and perm_start appear one cycle after the accepted beat / deciding state.
// Backpressure: s_tready is high only in LOAD; a low s_tvalid stalls the block position without losing it.
module keccak_absorb_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int RATE_WORDS = 68
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    keccak_absorb_ctrl_if.slave  bus
);

    localparam logic [7:0] IDX_LAST   = 8'(RATE_WORDS - 1);
    localparam logic [7:0] DEST_CLEAR = 8'hFF;

`ifdef ABSORB_PAD_EN
    // Keccak pad10*1 with SHA-3 domain bits: 0x06 opens the pad, the word MSB closes it.
    localparam logic [DATA_WIDTH-1:0] PAD_FIRST = DATA_WIDTH'(6);
    localparam logic [DATA_WIDTH-1:0] PAD_LAST  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, PAD, PERM, WAIT, DONE
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, PERM, WAIT, DONE
    } state_e;
`endif

    state_e                state_q, state_d;
    logic [7:0]            idx_q, idx_d;
    logic [15:0]           block_cnt_q, block_cnt_d;
    logic                  final_q, final_d;
    logic                  reg_we_q, reg_we_d;
    logic [7:0]            reg_dest_q, reg_dest_d;
    logic [DATA_WIDTH-1:0] reg_data_q, reg_data_d;
    logic                  perm_start_q, perm_start_d;
`ifdef ABSORB_PAD_EN
    logic                  pad_pend_q, pad_pend_d;
    logic                  pad_first_q, pad_first_d;
`endif

    logic blk_full;
    logic perm_ack;

    assign blk_full = (idx_q == IDX_LAST);
    // perm_start is registered, so a completion in the same cycle cannot belong to this request.
    assign perm_ack = bus.perm_done && !perm_start_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        block_cnt_d  = block_cnt_q;
        final_d      = final_q;
        reg_we_d     = 1'b0;
        reg_dest_d   = '0;
        reg_data_d   = '0;
        perm_start_d = 1'b0;
`ifdef ABSORB_PAD_EN
        pad_pend_d   = pad_pend_q;
        pad_first_d  = pad_first_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.s_tvalid) begin
                    state_d = CLEAR;
                end
            end

            CLEAR: begin
                reg_we_d    = 1'b1;
                reg_dest_d  = DEST_CLEAR;
                reg_data_d  = '0;
                block_cnt_d = '0;
                idx_d       = '0;
                final_d     = 1'b0;
`ifdef ABSORB_PAD_EN
                pad_pend_d  = 1'b0;
                pad_first_d = 1'b0;
`endif
                state_d     = LOAD;
            end

            LOAD: begin
                if (bus.s_tvalid) begin
                    reg_we_d   = 1'b1;
                    reg_dest_d = idx_q;
                    reg_data_d = bus.s_tdata;
                    if (bus.s_tlast) begin
                        final_d = 1'b1;
`ifdef ABSORB_PAD_EN
                        if (blk_full) begin
                            // Full block goes out first; padding then fills a fresh block.
                            state_d    = PERM;
                            idx_d      = '0;
                            pad_pend_d = 1'b1;
                        end else begin
                            state_d     = PAD;
                            idx_d       = idx_q + 8'd1;
                            pad_first_d = 1'b1;
                        end
`else
                        state_d = PERM;
                        idx_d   = '0;
`endif
                    end else if (blk_full) begin
                        state_d = PERM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end

`ifdef ABSORB_PAD_EN
            PAD: begin
                reg_we_d    = 1'b1;
                reg_dest_d  = idx_q;
                reg_data_d  = (pad_first_q ? PAD_FIRST : '0) | (blk_full ? PAD_LAST : '0);
                pad_first_d = 1'b0;
                if (blk_full) begin
                    state_d = PERM;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
`endif

            PERM: begin
                perm_start_d = 1'b1;
                block_cnt_d  = (block_cnt_q == 16'hFFFF) ? block_cnt_q : block_cnt_q + 16'd1;
                state_d      = WAIT;
            end

            WAIT: begin
                if (perm_ack) begin
                    if (!final_q) begin
                        state_d = LOAD;
`ifdef ABSORB_PAD_EN
                    end else if (pad_pend_q) begin
                        state_d     = PAD;
                        pad_pend_d  = 1'b0;
                        pad_first_d = 1'b1;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            block_cnt_q  <= '0;
            final_q      <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_dest_q   <= '0;
            reg_data_q   <= '0;
            perm_start_q <= 1'b0;
`ifdef ABSORB_PAD_EN
            pad_pend_q   <= 1'b0;
            pad_first_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            block_cnt_q  <= block_cnt_d;
            final_q      <= final_d;
            reg_we_q     <= reg_we_d;
            reg_dest_q   <= reg_dest_d;
            reg_data_q   <= reg_data_d;
            perm_start_q <= perm_start_d;
`ifdef ABSORB_PAD_EN
            pad_pend_q   <= pad_pend_d;
            pad_first_q  <= pad_first_d;
`endif
        end
    end

    assign bus.s_tready     = (state_q == LOAD);
    assign bus.busy         = (state_q != IDLE);
    assign bus.digest_valid = (state_q == DONE);
    assign bus.reg_we       = reg_we_q;
    assign bus.reg_dest     = reg_dest_q;
    assign bus.reg_data     = reg_data_q;
    assign bus.perm_start   = perm_start_q;
    assign bus.block_cnt    = block_cnt_q;

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Bench for keccak_absorb_ctrl: directed messages checked against an event-order model of clear/load/pad/permute.
module tb_keccak_absorb_ctrl;
    localparam int DW = 16;
    localparam int RW = 68;

`ifdef ABSORB_PAD_EN
    localparam int W3 = 69, W67 = 69, W68 = 137, W140 = 205, B68 = 2;
`else
    localparam int W3 = 4, W67 = 68, W68 = 69, W140 = 141, B68 = 1;
`endif

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    keccak_absorb_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    keccak_absorb_ctrl #(.DATA_WIDTH(DW), .RATE_WORDS(RW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    // kind: 0 = load-port write, 1 = permutation request, 2 = digest
    typedef struct {
        int kind;
        int dest;
        int data;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] msg[$];
    int  total = 0, bad = 0;
    int  exp_blocks = 0, perm_cnt = 0, wr_cnt = 0, last_blk = -1, first_dest = -1;
    int  perm_delay = 1;
    bit  done_seen = 0, perm_out = 0, acc_pend = 0, prev_we = 0, abort_drv = 0;
    logic pd_resp = 1'b0, pd_spur = 1'b0;

    assign bus.perm_done = pd_resp | pd_spur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] dest, input logic [31:0] data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event_order: got kind %0d dest %0d data 0x%0h, nothing expected", kind, dest, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.dest !== dest || e.data !== data) begin
                bad++;
                $display("FAIL event_order: got kind %0d dest %0d data 0x%0h want kind %0d dest %0d data 0x%0h",
                         kind, dest, data, e.kind, e.dest, e.data);
            end
        end
    endtask

    // Expected event sequence of one message, derived from block arithmetic on the word count.
    task automatic build_model(input int n);
        int blocks;
        blocks = 0;
        exp_q.delete();
        exp_q.push_back('{0, 255, 0});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{0, i % RW, int'(msg[i])});
`ifdef ABSORB_PAD_EN
            if (i % RW == RW - 1) begin
`else
            if (i % RW == RW - 1 || i == n - 1) begin
`endif
                exp_q.push_back('{1, 0, 0});
                blocks++;
            end
        end
`ifdef ABSORB_PAD_EN
        for (int j = n % RW; j < RW; j++) begin
            exp_q.push_back('{0, j, ((j == n % RW) ? 'h0006 : 0) | ((j == RW - 1) ? 'h8000 : 0)});
        end
        exp_q.push_back('{1, 0, 0});
        blocks++;
`endif
        exp_q.push_back('{2, 0, 0});
        exp_blocks = blocks;
    endtask

    task automatic fill_msg(input int n, input int seed);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(16'(seed + i * 37));
    endtask

    task automatic send_msg(input int n, input bit gap);
        bit rdy;
        int waited;
        for (int i = 0; i < n && !abort_drv; i++) begin
            if (gap && i > 0) begin
                bus.s_tvalid = 1'b0;
                @(posedge ACLK); #1;
            end
            bus.s_tdata  = msg[i];
            bus.s_tlast  = (i == n - 1);
            bus.s_tvalid = 1'b1;
            rdy    = 1'b0;
            waited = 0;
            while (!rdy && !abort_drv && waited < 3000) begin
                rdy = bus.s_tready;
                @(posedge ACLK); #1;
                waited++;
            end
            if (!abort_drv) chk("beat_accepted", rdy, 1);
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (!done_seen && c < 5000) begin
            @(posedge ACLK); #1;
            c++;
        end
        chk({name, "_digest"}, done_seen, 1);
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic run_msg(input string name, input int n, input bit gap, input int delay,
                           input int exp_wr, input int exp_blk);
        perm_delay = delay;
        wr_cnt     = 0;
        first_dest = -1;
        done_seen  = 0;
        perm_cnt   = 0;
        build_model(n);
        send_msg(n, gap);
        wait_done(name);
        chk({name, "_blocks"}, last_blk, exp_blk);
        chk({name, "_writes"}, wr_cnt, exp_wr);
        chk({name, "_first_is_clear"}, first_dest, 255);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    // Permutation engine stand-in: perm_done perm_delay cycles after perm_start.
    initial begin
        int cnt;
        cnt = -1;
        forever begin
            @(posedge ACLK); #2;
            pd_resp = 1'b0;
            if (!ARESETn) cnt = -1;
            else if (bus.perm_start) cnt = perm_delay;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    pd_resp = 1'b1;
                    cnt     = -1;
                end
            end
        end
    end

    // Per-cycle compare against the model and the handshake rules.
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                chk("rst_outputs", {bus.s_tready, bus.reg_we, bus.perm_start, bus.busy, bus.digest_valid,
                                    |bus.reg_dest, |bus.reg_data, |bus.block_cnt}, 0);
                acc_pend = 0;
                prev_we  = 0;
                perm_out = 0;
            end else begin
                if (acc_pend) chk("beat_write_latency", bus.reg_we, 1);
                if (bus.reg_we) begin
                    wr_cnt++;
                    if (wr_cnt == 1) first_dest = int'(bus.reg_dest);
                    expect_ev(0, bus.reg_dest, bus.reg_data);
                end
                if (bus.perm_start) begin
                    chk("perm_not_with_write", bus.reg_we, 0);
                    chk("perm_after_write", prev_we, 1);
                    perm_cnt++;
                    expect_ev(1, 0, 0);
                end
                if (bus.digest_valid) begin
                    expect_ev(2, 0, 0);
                    chk("block_cnt_model", bus.block_cnt, exp_blocks);
                    last_blk  = int'(bus.block_cnt);
                    done_seen = 1;
                end
                if (perm_out || bus.perm_start) chk("tready_low_in_wait", bus.s_tready, 0);
                if (bus.reg_we || bus.perm_start || perm_out || bus.digest_valid) chk("busy", bus.busy, 1);
                if (bus.perm_start) perm_out = 1;
                else if (bus.perm_done) perm_out = 0;
                acc_pend = bus.s_tvalid && bus.s_tready;
                prev_we  = bus.reg_we;
            end
        end
    end

    initial begin
        int c;
        bus.s_tdata  = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        ARESETn      = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_tready", bus.s_tready, 0);
        chk("reset_block_cnt", bus.block_cnt, 0);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        chk("idle_not_busy", bus.busy, 0);

        msg = '{16'h1111, 16'h2222, 16'h3333};
        run_msg("m3", 3, 1'b0, 1, W3, 1);

        pd_spur = 1'b1;
        @(posedge ACLK); #1;
        pd_spur = 1'b0;
        @(posedge ACLK); #1;
        chk("spurious_done_ignored", bus.busy, 0);

        fill_msg(67, 16'h4000);
        run_msg("m67", 67, 1'b0, 2, W67, 1);

        fill_msg(68, 16'h5100);
        run_msg("m68", 68, 1'b0, 1, W68, B68);

        fill_msg(140, 16'hA000);
        run_msg("m140_gap", 140, 1'b1, 24, W140, 3);

        // Reset while the second block's permutation is outstanding.
        fill_msg(140, 16'h7700);
        perm_delay = 24;
        perm_cnt   = 0;
        wr_cnt     = 0;
        done_seen  = 0;
        build_model(140);
        fork
            send_msg(140, 1'b1);
            begin
                c = 0;
                while (perm_cnt < 2 && c < 2000) begin
                    @(negedge ACLK); #1;
                    c++;
                end
                chk("reached_block2_wait", perm_cnt, 2);
                ARESETn   = 1'b0;
                abort_drv = 1'b1;
                #1;
                chk("async_rst_zero", {bus.s_tready, bus.reg_we, bus.perm_start, bus.busy, bus.digest_valid,
                                       |bus.reg_dest, |bus.reg_data, |bus.block_cnt}, 0);
            end
        join
        repeat (3) @(posedge ACLK);
        #1;
        exp_q.delete();
        abort_drv = 1'b0;
        ARESETn   = 1'b1;
        @(posedge ACLK); #1;
        chk("post_reset_idle", bus.busy, 0);
        chk("post_reset_no_digest", done_seen, 0);

        msg = '{16'hBEEF, 16'h0001, 16'hF00D};
        run_msg("post_reset", 3, 1'b0, 3, W3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
